// File: rtl/edge_check_top.sv
// edge_check_top: synchronise, glitch-filter and edge-detect an async input, emitting stretched pulses
module edge_check_top #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int EDGE_MODE     = 0,
  parameter int PULSE_CYCLES  = 1
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic signal_in,
  output logic signal_out
);
  localparam int PW = $clog2(PULSE_CYCLES + 1);
  logic [SYNC_STAGES-1:0] sync;
  logic s, filt, filt_d, rise, fall, hit;
  logic [PW-1:0] pcnt;
  assign s = sync[SYNC_STAGES-1];
  always_ff @(posedge sys_clk)
    sync <= sys_rst ? '0 : {sync[SYNC_STAGES-2:0], signal_in};
  generate
    if (FILTER_CYCLES == 0) begin : g_byp
      assign filt = s;
    end else begin : g_flt
      localparam int FW = $clog2(FILTER_CYCLES + 1);
      logic [FW-1:0] cnt;
      logic filt_q;
      always_ff @(posedge sys_clk)
        if (sys_rst) begin
          cnt <= '0;
          filt_q <= 1'b0;
        end else if (s == filt_q) cnt <= '0;
        else if (cnt == FW'(FILTER_CYCLES - 1)) begin
          filt_q <= s;
          cnt <= '0;
        end else cnt <= cnt + FW'(1);
      assign filt = filt_q;
    end
  endgenerate
  always_ff @(posedge sys_clk)
    filt_d <= sys_rst ? 1'b0 : filt;
  always_comb begin
    rise = filt & ~filt_d;
    fall = ~filt & filt_d;
    hit = EDGE_MODE == 0 ? rise : EDGE_MODE == 1 ? fall : (rise | fall);
  end
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      signal_out <= 1'b0;
      pcnt <= '0;
    end else if (hit) begin
      signal_out <= 1'b1;
      pcnt <= PW'(PULSE_CYCLES - 1);
    end else if (pcnt != '0) pcnt <= pcnt - PW'(1);
    else signal_out <= 1'b0;
endmodule

// File: tb/tb_edge_check_top.sv
// tb_edge_check_top: randomized segment-level scoreboard check of two edge_check_top configurations
module tb_edge_check_top;
  localparam int S_A = 2, F_A = 4, M_A = 0, P_A = 1;
  localparam int S_B = 3, F_B = 0, M_B = 2, P_B = 5;
  localparam int MAXC = 8192;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic signal_in = 1'b0;
  logic out_a, out_b;
  edge_check_top dut_a (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .signal_in(signal_in),
    .signal_out(out_a)
  );
  edge_check_top #(
    .SYNC_STAGES(S_B),
    .FILTER_CYCLES(F_B),
    .EDGE_MODE(M_B),
    .PULSE_CYCLES(P_B)
  ) dut_b (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .signal_in(signal_in),
    .signal_out(out_b)
  );
  always #5 sys_clk = ~sys_clk;
  typedef struct {
    bit a;
    bit b;
    int c;
  } exp_t;
  bit rst_tl[MAXC];
  bit in_tl[MAXC];
  bit ea[MAXC];
  bit eb[MAXC];
  int n_cyc = 0;
  exp_t sbq[$];
  int compared = 0;
  int mismatched = 0;
  task automatic apply_model(input int sel, input int g0, input int pend, input int lv[$], input int ln[$]);
    int s, f, m, p, acc, pos, e;
    s = sel ? S_B : S_A;
    f = sel ? F_B : F_A;
    m = sel ? M_B : M_A;
    p = sel ? P_B : P_A;
    acc = 0;
    pos = 0;
    foreach (lv[i]) begin
      if (lv[i] != acc && ln[i] >= (f > 0 ? f : 1)) begin
        e = g0 + pos + s + f;
        acc = lv[i];
        if (m == 2 || (m == 0 && acc == 1) || (m == 1 && acc == 0))
          for (int t = e; t < e + p && t < pend; t++)
            if (sel != 0) eb[t] = 1'b1;
            else ea[t] = 1'b1;
      end
      pos += ln[i];
    end
  endtask
  task automatic add_phase(input int rlen, input int lv[$], input int ln[$]);
    int g0, pend;
    for (int i = 0; i < rlen && n_cyc < MAXC; i++) begin
      rst_tl[n_cyc] = 1'b1;
      in_tl[n_cyc] = 1'($urandom_range(0, 1));
      n_cyc++;
    end
    g0 = n_cyc;
    foreach (lv[i])
      for (int k = 0; k < ln[i] && n_cyc < MAXC; k++) begin
        rst_tl[n_cyc] = 1'b0;
        in_tl[n_cyc] = (lv[i] != 0);
        n_cyc++;
      end
    pend = n_cyc;
    apply_model(0, g0, pend, lv, ln);
    apply_model(1, g0, pend, lv, ln);
  endtask
  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge sys_clk);
      if (sbq.size() != 0) begin
        x = sbq.pop_front();
        compared++;
        if (out_a !== x.a) begin
          mismatched++;
          $display("FAIL out_a cycle %0d: got %b expected %b", x.c, out_a, x.a);
        end
        compared++;
        if (out_b !== x.b) begin
          mismatched++;
          $display("FAIL out_b cycle %0d: got %b expected %b", x.c, out_b, x.b);
        end
      end
    end
  end
  initial begin : watchdog
    #(500_000);
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "timeout");
  end
  initial begin : driver
    int lv[$];
    int ln[$];
    int lvl;
    lv = '{0, 1, 0, 1, 0, 1, 0};
    ln = '{10, 3, 10, 4, 12, 1, 9};
    add_phase(4, lv, ln);
    lv = '{0, 1};
    ln = '{5, 6};
    add_phase(2, lv, ln);
    lv = '{1, 0, 1, 0};
    ln = '{14, 7, 2, 15};
    add_phase(3, lv, ln);
    for (int ph = 0; ph < 8; ph++) begin
      lv.delete();
      ln.delete();
      lvl = int'($urandom_range(0, 1));
      for (int sg = 0; sg < int'($urandom_range(15, 40)); sg++) begin
        lv.push_back(lvl);
        ln.push_back($urandom_range(0, 3) == 0 ? int'($urandom_range(5, 25)) : int'($urandom_range(1, 6)));
        lvl = 1 - lvl;
      end
      add_phase(int'($urandom_range(1, 4)), lv, ln);
    end
    lv.delete();
    ln.delete();
    add_phase(3, lv, ln);
    sys_rst = rst_tl[0];
    signal_in = in_tl[0];
    for (int c = 0; c < n_cyc; c++) begin
      @(posedge sys_clk);
      #1;
      sbq.push_back('{ea[c], eb[c], c});
      if (c + 1 < n_cyc) begin
        sys_rst = rst_tl[c + 1];
        signal_in = in_tl[c + 1];
      end
    end
    @(negedge sys_clk);
    @(negedge sys_clk);
    compared++;
    if (sbq.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
